// File: rtl/pdm_stereo_deserializer.sv
// pdm_stereo_deserializer
//   Generates the PDM bit clock, shifts PDM data MSB-first into
//   WORD_LENGTH-bit words and queues completed words in a 2-entry FIFO
//   with a valid/ready handshake and a sticky overrun flag.
//
//   Optional feature macro: PDM_DESER_STEREO_EN
//     defined   : left captured on pdm_clk_o falling edges, right on rising
//                 edges; the board straps each microphone's lrsel.
//     undefined : left channel only, channel_o is always 0.
//
// Ports
//   clock_i      system clock
//   reset_i      asynchronous active-high reset
//   enable_i     run enable; low clears the datapath, keeps the FIFO
//   pdm_clk_o    PDM bit clock (SYSTEM_FREQUENCY / (2*HALF_PERIOD))
//   pdm_data_i   PDM data from the microphone(s)
//   pdm_lrsel_o  microphone L/R select, held 0
//   data_o       FIFO head word
//   channel_o    FIFO head channel (0 left, 1 right)
//   valid_o      FIFO non-empty
//   ready_i      consumer accepts the head word
//   overrun_o    sticky: a completed word was dropped on a full FIFO

// Per-channel shift register and bit counter. done_o/word_o are
// combinational so the parent can register the completed word on the
// same edge that performs the final capture.
module pdm_deser_chan #(
    parameter int WORD_LENGTH = 16
) (
    input  logic                   clock_i,
    input  logic                   reset_i,
    input  logic                   enable_i,
    input  logic                   capture_i,
    input  logic                   bit_i,
    output logic                   done_o,
    output logic [WORD_LENGTH-1:0] word_o
);
    localparam int BW = $clog2(WORD_LENGTH);

    // Only W-1 bits need storing: the newest bit comes straight from bit_i.
    logic [WORD_LENGTH-2:0] sr;
    logic [BW-1:0]          bcnt;
    logic                   last;

    assign last   = (bcnt == BW'(WORD_LENGTH - 1));
    assign word_o = {sr, bit_i};
    assign done_o = capture_i && last;

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            sr   <= '0;
            bcnt <= '0;
        end else if (!enable_i) begin
            sr   <= '0;
            bcnt <= '0;
        end else if (capture_i) begin
            sr   <= word_o[WORD_LENGTH-2:0];
            bcnt <= last ? '0 : bcnt + 1'b1;
        end
    end
endmodule

module pdm_stereo_deserializer #(
    parameter int WORD_LENGTH        = 16,
    parameter int SYSTEM_FREQUENCY   = 100000000,
    parameter int SAMPLING_FREQUENCY = 1000000
) (
    input  logic                   clock_i,
    input  logic                   reset_i,
    input  logic                   enable_i,
    output logic                   pdm_clk_o,
    input  logic                   pdm_data_i,
    output logic                   pdm_lrsel_o,
    output logic [WORD_LENGTH-1:0] data_o,
    output logic                   channel_o,
    output logic                   valid_o,
    input  logic                   ready_i,
    output logic                   overrun_o
);
    localparam int HALF_PERIOD = SYSTEM_FREQUENCY / (2 * SAMPLING_FREQUENCY);
    localparam int CW          = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;

    generate
        if (HALF_PERIOD < 2 || (SYSTEM_FREQUENCY % (2 * SAMPLING_FREQUENCY)) != 0) begin : g_bad_div
            $error("pdm_stereo_deserializer: HALF_PERIOD must be an integer >= 2");
        end
        if (WORD_LENGTH < 2 || WORD_LENGTH > 32) begin : g_bad_wl
            $error("pdm_stereo_deserializer: WORD_LENGTH must be 2..32");
        end
    endgenerate

    typedef struct packed {
        logic                   ch;
        logic [WORD_LENGTH-1:0] word;
    } entry_t;

    // ---------------- bit clock divider ----------------
    logic [CW-1:0] cnt;
    logic          pdm_clk_q;
    logic          wrap;

    assign wrap = enable_i && (cnt == CW'(HALF_PERIOD - 1));

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            cnt       <= '0;
            pdm_clk_q <= 1'b0;
        end else if (!enable_i) begin
            cnt       <= '0;
            pdm_clk_q <= 1'b0;
        end else if (wrap) begin
            cnt       <= '0;
            pdm_clk_q <= ~pdm_clk_q;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    // ---------------- channel capture ----------------
    // Left samples on the edge that drives pdm_clk_o 1->0.
    logic                   cap_l, done_l, done_r;
    logic [WORD_LENGTH-1:0] word_l, word_r;

    assign cap_l = wrap && pdm_clk_q;

    pdm_deser_chan #(.WORD_LENGTH(WORD_LENGTH)) u_left (
        .clock_i   (clock_i),
        .reset_i   (reset_i),
        .enable_i  (enable_i),
        .capture_i (cap_l),
        .bit_i     (pdm_data_i),
        .done_o    (done_l),
        .word_o    (word_l)
    );

`ifdef PDM_DESER_STEREO_EN
    // Right samples on the edge that drives pdm_clk_o 0->1.
    logic cap_r;
    assign cap_r = wrap && !pdm_clk_q;

    pdm_deser_chan #(.WORD_LENGTH(WORD_LENGTH)) u_right (
        .clock_i   (clock_i),
        .reset_i   (reset_i),
        .enable_i  (enable_i),
        .capture_i (cap_r),
        .bit_i     (pdm_data_i),
        .done_o    (done_r),
        .word_o    (word_r)
    );
`else
    assign done_r = 1'b0;
    assign word_r = '0;
`endif

    // ---------------- write request register ----------------
    // Channels complete on opposite pdm_clk edges, so one request slot
    // is enough.
    entry_t req;
    logic   req_vld;

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            req_vld <= 1'b0;
            req     <= '0;
        end else if (!enable_i) begin
            req_vld <= 1'b0;
        end else begin
            req_vld <= done_l || done_r;
            if (done_l || done_r)
                req <= {done_r, (done_r ? word_r : word_l)};
        end
    end

    // ---------------- 2-entry output FIFO ----------------
    // slot0 is always the head, so data_o/channel_o come straight from a
    // register and cannot move while the consumer stalls.
    entry_t     slot0, slot1;
    logic [1:0] count;
    logic       overrun_q;
    logic       push, pop;

    // A request still pending when enable drops is discarded.
    assign push = req_vld && enable_i;
    assign pop  = (count != 2'd0) && ready_i;

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            slot0     <= '0;
            slot1     <= '0;
            count     <= 2'd0;
            overrun_q <= 1'b0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (count == 2'd0) begin
                        slot0 <= req;
                        count <= 2'd1;
                    end else if (count == 2'd1) begin
                        slot1 <= req;
                        count <= 2'd2;
                    end
                end
                2'b01: begin
                    slot0 <= slot1;
                    count <= count - 2'd1;
                end
                2'b11: begin
                    // Occupancy unchanged; a full FIFO shifts and refills.
                    if (count == 2'd2) begin
                        slot0 <= slot1;
                        slot1 <= req;
                    end else begin
                        slot0 <= req;
                    end
                end
                default: ;
            endcase

            if (!enable_i)
                overrun_q <= 1'b0;
            else if (push && !pop && count == 2'd2)
                overrun_q <= 1'b1;
        end
    end

    assign pdm_clk_o   = pdm_clk_q;
    assign pdm_lrsel_o = 1'b0;
    assign data_o      = slot0.word;
    assign channel_o   = slot0.ch;
    assign valid_o     = (count != 2'd0);
    assign overrun_o   = overrun_q;
endmodule

// File: tb/tb_pdm_stereo_deserializer.sv
// Directed bench for pdm_stereo_deserializer with WORD_LENGTH=4,
// HALF_PERIOD=2. Cycle c is the clock period ending at rising edge c;
// enabled cycles count from 1. Inputs change 1 time unit after a rising
// edge, outputs are sampled on the falling edge inside the cycle.
module tb_pdm_stereo_deserializer;
    localparam int W = 4;

    logic         clock_i = 1'b0;
    logic         reset_i, enable_i, pdm_data_i, ready_i;
    logic         pdm_clk_o, pdm_lrsel_o, channel_o, valid_o, overrun_o;
    logic [W-1:0] data_o;

    int n_vec = 0;
    int n_err = 0;

    pdm_stereo_deserializer #(
        .WORD_LENGTH        (W),
        .SYSTEM_FREQUENCY   (8),
        .SAMPLING_FREQUENCY (2)
    ) dut (
        .clock_i     (clock_i),
        .reset_i     (reset_i),
        .enable_i    (enable_i),
        .pdm_clk_o   (pdm_clk_o),
        .pdm_data_i  (pdm_data_i),
        .pdm_lrsel_o (pdm_lrsel_o),
        .data_o      (data_o),
        .channel_o   (channel_o),
        .valid_o     (valid_o),
        .ready_i     (ready_i),
        .overrun_o   (overrun_o)
    );

    always #5 clock_i = ~clock_i;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, got, exp);
        end
    endtask

    // Advance to the next cycle and drive its inputs, then wait for the
    // mid-cycle sample point.
    task automatic step(input logic en, input logic rdy, input logic din);
        @(posedge clock_i);
        #1;
        enable_i   = en;
        ready_i    = rdy;
        pdm_data_i = din;
        @(negedge clock_i);
    endtask

    // Leaves the bench in cycle 0 (enable low), reset released.
    task automatic do_reset();
        reset_i    = 1'b1;
        enable_i   = 1'b0;
        ready_i    = 1'b0;
        pdm_data_i = 1'b0;
        repeat (2) @(posedge clock_i);
        #1 reset_i = 1'b0;
        @(negedge clock_i);
    endtask

    // Bit of word w sampled at the falling edge closing word-cycle c (1..16).
    function automatic logic wbit(input logic [3:0] w, input int c);
        int idx;
        if (c < 1 || c > 16) return 1'b0;
        idx = 3 - (c - 1) / 4;
        return w[idx];
    endfunction

`ifndef PDM_DESER_STEREO_EN
    logic [3:0] wq [4];

    function automatic logic stream_bit(input int c);
        return wbit(wq[(c - 1) / 16], ((c - 1) % 16) + 1);
    endfunction

    typedef struct packed {
        logic       din;
        logic       exp_clk;
        logic       exp_vld;
        logic [3:0] exp_data;
    } vec_t;
    vec_t tbl [19];
`endif

    initial begin
`ifndef PDM_DESER_STEREO_EN
        // Mono word 1011: bits sampled at falling edges 4, 8, 12, 16.
        tbl[0]  = '{1'b1, 1'b0, 1'b0, 4'h0};
        tbl[1]  = '{1'b1, 1'b0, 1'b0, 4'h0};
        tbl[2]  = '{1'b1, 1'b1, 1'b0, 4'h0};
        tbl[3]  = '{1'b1, 1'b1, 1'b0, 4'h0};
        tbl[4]  = '{1'b0, 1'b0, 1'b0, 4'h0};
        tbl[5]  = '{1'b0, 1'b0, 1'b0, 4'h0};
        tbl[6]  = '{1'b0, 1'b1, 1'b0, 4'h0};
        tbl[7]  = '{1'b0, 1'b1, 1'b0, 4'h0};
        tbl[8]  = '{1'b1, 1'b0, 1'b0, 4'h0};
        tbl[9]  = '{1'b1, 1'b0, 1'b0, 4'h0};
        tbl[10] = '{1'b1, 1'b1, 1'b0, 4'h0};
        tbl[11] = '{1'b1, 1'b1, 1'b0, 4'h0};
        tbl[12] = '{1'b1, 1'b0, 1'b0, 4'h0};
        tbl[13] = '{1'b1, 1'b0, 1'b0, 4'h0};
        tbl[14] = '{1'b1, 1'b1, 1'b0, 4'h0};
        tbl[15] = '{1'b1, 1'b1, 1'b0, 4'h0};
        tbl[16] = '{1'b0, 1'b0, 1'b0, 4'h0};
        tbl[17] = '{1'b0, 1'b0, 1'b1, 4'hB};
        tbl[18] = '{1'b0, 1'b1, 1'b0, 4'h0};
`endif

        do_reset();
        chk("rst_clk",   pdm_clk_o,   0);
        chk("rst_vld",   valid_o,     0);
        chk("rst_data",  data_o,      0);
        chk("rst_ch",    channel_o,   0);
        chk("rst_ovr",   overrun_o,   0);
        chk("rst_lrsel", pdm_lrsel_o, 0);

`ifndef PDM_DESER_STEREO_EN
        // ---- table: one mono word, ready held high ----
        for (int i = 0; i < 19; i++) begin
            step(1'b1, 1'b1, tbl[i].din);
            chk($sformatf("tbl%0d_clk", i + 1), pdm_clk_o, tbl[i].exp_clk);
            chk($sformatf("tbl%0d_vld", i + 1), valid_o,   tbl[i].exp_vld);
            if (tbl[i].exp_vld) begin
                chk($sformatf("tbl%0d_data", i + 1), data_o,    tbl[i].exp_data);
                chk($sformatf("tbl%0d_ch",   i + 1), channel_o, 0);
            end
        end

        // ---- reset mid-stream with a queued word and a partial word ----
        do_reset();
        wq[0] = 4'b1110; wq[1] = 4'b1111; wq[2] = 4'h0; wq[3] = 4'h0;
        for (int c = 1; c <= 24; c++) begin
            step(1'b1, 1'b0, stream_bit(c));
            if (c == 18) chk("mid_pre_data", data_o, 4'hE);
            if (c == 24) begin
                chk("mid_pre_vld", valid_o,   1);
                chk("mid_pre_clk", pdm_clk_o, 1);
            end
        end
        reset_i = 1'b1;
        #1;
        chk("mid_rst_vld",  valid_o,   0);
        chk("mid_rst_data", data_o,    0);
        chk("mid_rst_clk",  pdm_clk_o, 0);
        chk("mid_rst_ovr",  overrun_o, 0);
        do_reset();
        wq[0] = 4'b0110; wq[1] = 4'h0;
        for (int c = 1; c <= 18; c++) begin
            step(1'b1, 1'b1, stream_bit(c));
            if (c == 17) chk("post_rst_vld17", valid_o, 0);
            if (c == 18) begin
                chk("post_rst_vld18",  valid_o, 1);
                chk("post_rst_data18", data_o,  4'h6);
            end
        end

        // ---- backpressure/overrun, then enable drop and re-enable ----
        do_reset();
        wq[0] = 4'b1001; wq[1] = 4'b0111; wq[2] = 4'b1111; wq[3] = 4'b1111;
        for (int c = 1; c <= 85; c++) begin
            logic en, rdy, din;
            en  = !(c >= 58 && c <= 67);
            rdy = (c == 53) || (c >= 60);
            if (c <= 57)      din = stream_bit(c);
            else if (c <= 67) din = 1'b1;
            else              din = wbit(4'b0100, c - 67);
            step(en, rdy, din);
            if (c == 20) begin
                chk("bp_vld20",  valid_o, 1);
                chk("bp_data20", data_o,  4'h9);
            end
            if (c == 49) chk("bp_ovr49", overrun_o, 0);
            if (c == 50) chk("bp_ovr50", overrun_o, 1);
            if (c == 53) chk("bp_pop1",  data_o,    4'h9);
            if (c == 54) begin
                chk("bp_pop2",  data_o,    4'h7);
                chk("bp_ovr54", overrun_o, 1);
            end
            if (c == 59) begin
                chk("dis_clk59",  pdm_clk_o, 0);
                chk("dis_ovr59",  overrun_o, 0);
                chk("dis_vld59",  valid_o,   1);
                chk("dis_data59", data_o,    4'h7);
            end
            if (c >= 61 && c <= 84) chk($sformatf("reen_idle%0d", c), valid_o, 0);
            if (c == 85) begin
                chk("reen_vld",  valid_o,   1);
                chk("reen_data", data_o,    4'h4);
                chk("reen_ch",   channel_o, 0);
            end
        end

        // ---- full FIFO: push and pop on the same edge ----
        do_reset();
        wq[0] = 4'b0001; wq[1] = 4'b1000; wq[2] = 4'b1010; wq[3] = 4'h0;
        for (int c = 1; c <= 52; c++) begin
            step(1'b1, (c >= 49), stream_bit(c));
            if (c == 48) chk("full_head48", data_o, 4'h1);
            if (c == 50) begin
                chk("full_ovr50",  overrun_o, 0);
                chk("full_data50", data_o,    4'h8);
            end
            if (c == 51) begin
                chk("full_vld51",  valid_o, 1);
                chk("full_data51", data_o,  4'hA);
            end
            if (c == 52) begin
                chk("full_vld52", valid_o,   0);
                chk("full_ovr52", overrun_o, 0);
            end
        end
`else
        // ---- stereo: left = 1 at falling edges, right = 0 at rising ----
        for (int c = 1; c <= 18; c++) begin
            step(1'b1, 1'b1, (c % 4 == 0));
            if (c == 15) chk("st_vld15", valid_o, 0);
            if (c == 16) begin
                chk("st_vld16",  valid_o,   1);
                chk("st_data16", data_o,    4'h0);
                chk("st_ch16",   channel_o, 1);
            end
            if (c == 17) chk("st_vld17", valid_o, 0);
            if (c == 18) begin
                chk("st_vld18",   valid_o,     1);
                chk("st_data18",  data_o,      4'hF);
                chk("st_ch18",    channel_o,   0);
                chk("st_lrsel18", pdm_lrsel_o, 0);
            end
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
